// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the buffered UART transmitter:
//             transmit FSM state encoding, parity selectors, default divisor.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int DEFAULT_DIV = 434;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with registered full/empty/count status and
//             a combinational head-of-queue read port (rdata shows the oldest
//             entry whenever empty is low).
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A push into a full FIFO is ignored; a pop from an empty one likewise.
    assign w_push_ok = push && !r_full;
    assign w_pop_ok  = pop  && !r_empty;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and status flags, all updated from the same next-count value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Buffered serial transmitter. CPU writes land in a FIFO; the
//             transmit FSM frames each word as start / data (LSB first) /
//             optional parity / 1-2 stop bits, running back-to-back frames
//             while the FIFO has data. Sticky overflow flag for dropped writes.
//  Options  : UART_TX_DIV_PORT_EN - adds div_in[15:0]; the bit period is
//             latched from it at every frame start (values below 2 act as 2).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DIV       = uart_pkg::DEFAULT_DIV,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [DATA_BITS-1:0]         wr_data,
    input  logic                         ovf_clr,
`ifdef UART_TX_DIV_PORT_EN
    input  logic [15:0]                  div_in,
`endif
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         overflow,
    output logic                         txd
);

    import uart_pkg::*;

`ifdef UART_TX_DIV_PORT_EN
    localparam int c_BAUD_W = 16;
`else
    localparam int c_BAUD_W = $clog2(DIV);
`endif
    localparam int                c_BIT_W     = $clog2(DATA_BITS);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);

    tx_state_e              r_state;
    logic [c_BAUD_W-1:0]    r_baud;
    logic [c_BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_txd;
    logic                   r_busy;
    logic                   r_ovf;

    logic [DATA_BITS-1:0]   w_rdata;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_par_calc;
    logic [c_BAUD_W-1:0]    w_load_m1;
    logic [c_BAUD_W-1:0]    w_reload;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (w_pop),
        .wdata (wr_data),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    // A word is taken from the FIFO when idle, or at the very end of the last
    // stop bit so the next start bit follows without an idle gap.
    assign w_pop = !w_empty &&
                   ((r_state == uart_pkg::IDLE) ||
                    ((r_state == uart_pkg::STOP) && (r_baud == '0) && (r_bit == c_LAST_STOP)));

    // Parity is taken from the popped word so it travels with its frame.
    assign w_par_calc = (PARITY == PARITY_ODD) ? ~(^w_rdata) : (^w_rdata);

`ifdef UART_TX_DIV_PORT_EN
    logic [15:0] r_div_m1;

    assign w_load_m1 = (div_in < 16'd2) ? 16'd1 : (div_in - 16'd1);
    assign w_reload  = r_div_m1;

    // Bit period is frozen per frame so div_in changes never disturb a frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_m1 <= 16'd1;
        end else if (w_pop) begin
            r_div_m1 <= w_load_m1;
        end
    end
`else
    assign w_load_m1 = c_BAUD_W'(DIV - 1);
    assign w_reload  = c_BAUD_W'(DIV - 1);
`endif

    // Sticky overflow: a dropped write sets it and wins over a same-edge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (wr_en && w_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Transmit FSM: every bit lasts one full bit period, counted down to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= uart_pkg::IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                uart_pkg::IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_state <= uart_pkg::START;
                        r_shift <= w_rdata;
                        r_par   <= w_par_calc;
                        r_baud  <= w_load_m1;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                uart_pkg::START: begin
                    if (r_baud == '0) begin
                        r_state <= uart_pkg::DATA;
                        r_bit   <= '0;
                        r_baud  <= w_reload;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                uart_pkg::DATA: begin
                    if (r_baud == '0) begin
                        r_baud <= w_reload;
                        if (r_bit == c_LAST_BIT) begin
                            r_bit <= '0;
                            if (PARITY != PARITY_NONE) begin
                                r_state <= uart_pkg::PARITY;
                                r_txd   <= r_par;
                            end else begin
                                r_state <= uart_pkg::STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                uart_pkg::PARITY: begin
                    if (r_baud == '0) begin
                        r_state <= uart_pkg::STOP;
                        r_bit   <= '0;
                        r_baud  <= w_reload;
                        r_txd   <= 1'b1;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                uart_pkg::STOP: begin
                    if (r_baud == '0) begin
                        if (r_bit != c_LAST_STOP) begin
                            r_bit  <= r_bit + 1'b1;
                            r_baud <= w_reload;
                        end else if (w_pop) begin
                            r_state <= uart_pkg::START;
                            r_bit   <= '0;
                            r_shift <= w_rdata;
                            r_par   <= w_par_calc;
                            r_baud  <= w_load_m1;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= uart_pkg::IDLE;
                            r_bit   <= '0;
                            r_busy  <= 1'b0;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_state <= uart_pkg::IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign busy     = r_busy;
    assign overflow = r_ovf;
    assign txd      = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo. Three differently
//             configured instances share one stimulus stream; a queue-based
//             line model predicts every output on every cycle, and a table of
//             hand-built frames checks the serial waveform directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int N = 3;

    // Instance configurations: A = 8N1, B = 8E2, C = 7O1 with a shorter bit.
    int P_DIV   [N] = '{4, 4, 3};
    int P_DB    [N] = '{8, 8, 7};
    int P_PAR   [N] = '{0, 2, 1};
    int P_STOP  [N] = '{1, 2, 1};
    int P_DEPTH [N] = '{4, 4, 8};

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
`ifdef UART_TX_DIV_PORT_EN
    logic [15:0] div_in = 16'd4;
`endif

    logic [N-1:0] full, empty, busy, ovf, txd;
    logic [2:0]   cnt_a, cnt_b;
    logic [3:0]   cnt_c;
    logic [3:0]   cnt [N];

    assign cnt[0] = {1'b0, cnt_a};
    assign cnt[1] = {1'b0, cnt_b};
    assign cnt[2] = cnt_c;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
`ifdef UART_TX_DIV_PORT_EN
        .div_in(div_in),
`endif
        .full(full[0]), .empty(empty[0]), .count(cnt_a), .busy(busy[0]),
        .overflow(ovf[0]), .txd(txd[0]));

    uart_tx_fifo #(.DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
`ifdef UART_TX_DIV_PORT_EN
        .div_in(div_in),
`endif
        .full(full[1]), .empty(empty[1]), .count(cnt_b), .busy(busy[1]),
        .overflow(ovf[1]), .txd(txd[1]));

    uart_tx_fifo #(.DIV(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .DEPTH(8)) u_c (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data[6:0]), .ovf_clr(ovf_clr),
`ifdef UART_TX_DIV_PORT_EN
        .div_in(div_in),
`endif
        .full(full[2]), .empty(empty[2]), .count(cnt_c), .busy(busy[2]),
        .overflow(ovf[2]), .txd(txd[2]));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int flen(input int d);
        return 1 + P_DB[d] + ((P_PAR[d] != 0) ? 1 : 0) + P_STOP[d];
    endfunction

    function automatic int cur_div(input int d);
`ifdef UART_TX_DIV_PORT_EN
        return (div_in < 16'd2) ? 2 : int'(div_in);
`else
        return P_DIV[d];
`endif
    endfunction

    // Level of the serial line at frame bit position i for word v.
    function automatic bit fbit(input int d, input logic [7:0] v, input int i);
        logic [7:0] m;
        m = v & 8'((1 << P_DB[d]) - 1);
        if (i == 0) return 1'b0;
        if (i <= P_DB[d]) return m[i-1];
        if ((P_PAR[d] != 0) && (i == P_DB[d] + 1)) return (P_PAR[d] == 2) ? ^m : ~(^m);
        return 1'b1;
    endfunction

    logic [7:0] m_mem  [N][8];
    int         m_head [N];
    int         m_size [N];
    bit         m_act  [N];
    int         m_pos  [N];
    int         m_div  [N];
    logic [7:0] m_cur  [N];
    bit         m_ovf  [N];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < N; d++) begin
                m_head[d] = 0; m_size[d] = 0; m_act[d] = 0; m_pos[d] = 0; m_ovf[d] = 0;
            end
        end else begin
            for (int d = 0; d < N; d++) begin
                int sz;
                int tail;
                sz   = m_size[d];
                tail = (m_head[d] + sz) % P_DEPTH[d];
                if (m_act[d]) begin
                    m_pos[d]++;
                    if (m_pos[d] == flen(d) * m_div[d]) m_act[d] = 0;
                end
                if (!m_act[d] && sz > 0) begin
                    m_cur[d]  = m_mem[d][m_head[d]];
                    m_head[d] = (m_head[d] + 1) % P_DEPTH[d];
                    m_size[d]--;
                    m_act[d]  = 1;
                    m_pos[d]  = 0;
                    m_div[d]  = cur_div(d);
                end
                if (wr_en && sz < P_DEPTH[d]) begin
                    m_mem[d][tail] = wr_data & 8'((1 << P_DB[d]) - 1);
                    m_size[d]++;
                end
                if (wr_en && sz == P_DEPTH[d]) m_ovf[d] = 1;
                else if (ovf_clr) m_ovf[d] = 0;
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < N; d++) begin
                logic       e_txd;
                logic [8:0] e_vec;
                e_txd = m_act[d] ? fbit(d, m_cur[d], m_pos[d] / m_div[d]) : 1'b1;
                e_vec = {e_txd, m_act[d], (m_size[d] == P_DEPTH[d]), (m_size[d] == 0),
                         m_ovf[d], 4'(m_size[d])};
                check($sformatf("model_dut%0d", d),
                      {txd[d], busy[d], full[d], empty[d], ovf[d], cnt[d]}, e_vec);
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0]  data;
        logic [11:0] fa;   // frame bits for A, bit 0 = start bit
        logic [11:0] fb;
        logic [11:0] fc;
    } vec_t;

    vec_t tbl [5];

    task automatic wait_idle();
        int t;
        t = 0;
        while (!((busy == '0) && (&empty)) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait_timeout", 32'(t < 2000), 32'd1);
    endtask

    task automatic run_entry(input int e);
        int         dv;
        int         len;
        logic [11:0] f;
        logic [1:0]  exp2;
        wait_idle();
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = tbl[e].data;
        @(negedge clk);
        wr_en = 1'b0;
        check($sformatf("write_latency%0d", e), {txd[0], cnt[0]}, {1'b1, 4'd1});
        for (int k = 0; k <= 48; k++) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                dv  = cur_div(d);
                len = flen(d) * dv;
                f   = (d == 0) ? tbl[e].fa : (d == 1) ? tbl[e].fb : tbl[e].fc;
                exp2 = (k < len) ? {f[k / dv], 1'b1} : 2'b10;
                check($sformatf("frame%0d_dut%0d_k%0d", e, d, k), {txd[d], busy[d]}, exp2);
            end
        end
    endtask

    initial begin
        int gap;
        tbl[0] = '{data: 8'hA5, fa: 12'h34A, fb: 12'hD4A, fc: 12'h24A};
        tbl[1] = '{data: 8'h07, fa: 12'h20E, fb: 12'hE0E, fc: 12'h20E};
        tbl[2] = '{data: 8'h3C, fa: 12'h278, fb: 12'hC78, fc: 12'h378};
        tbl[3] = '{data: 8'hFF, fa: 12'h3FE, fb: 12'hDFE, fc: 12'h2FE};
        tbl[4] = '{data: 8'h81, fa: 12'h302, fb: 12'hD02, fc: 12'h202};

        // Reset for 4 cycles, then 100 idle cycles.
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            for (int d = 0; d < N; d++)
                check($sformatf("idle_dut%0d", d),
                      {txd[d], busy[d], empty[d], ovf[d], cnt[d]}, {4'b1010, 4'd0});
        end

        // Single frames from the table.
        for (int e = 0; e < 4; e++) run_entry(e);

        // Back-to-back frames and overflow.
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'(8'h11 * (i + 1));
        end
        @(negedge clk);
        check("peak_count_a", {ovf[0], cnt[0]}, {1'b0, 4'd4});
        wr_data = 8'h66;
        @(negedge clk);
        wr_en = 1'b0;
        check("drop_ovf_a", {ovf[0], cnt[0]}, {1'b1, 4'd4});
        check("drop_ovf_b", {ovf[1], cnt[1]}, {1'b1, 4'd4});
        gap = 0;
        for (int i = 0; i < 190; i++) begin
            @(negedge clk);
            if (!busy[0]) gap++;
        end
        check("b2b_no_gap_a", gap, 0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clear_a", ovf[0], 1'b0);
        wait_idle();

        // Reset in the middle of data bit 3 of 0x3C.
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (19) @(negedge clk);
        check("midframe_busy_a", busy[0], 1'b1);
        #2 reset = 1'b0;
        #1;
        check("reset_txd", txd, 3'b111);
        check("reset_cnt", {busy, cnt[0], cnt[1], cnt[2]}, 15'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        gap = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy[0] || !txd[0]) gap++;
        end
        check("no_residual_frame", gap, 0);
        run_entry(4);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 99) < 8);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 99) < 3);
        end
        @(negedge clk);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        wait_idle();

`ifdef UART_TX_DIV_PORT_EN
        // Divisor latched per frame: 8 for the first, 3 for the next.
        for (int f = 0; f < 2; f++) begin
            wait_idle();
            @(negedge clk);
            if (f == 0) div_in = 16'd8;
            wr_en   = 1'b1;
            wr_data = 8'h5A;
            @(negedge clk);
            wr_en = 1'b0;
            gap = 0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (busy[0]) gap++;
                if (gap == 10) div_in = 16'd3;
                if (!busy[0] && gap > 0) break;
            end
            check($sformatf("div_frame%0d_len", f), gap, (f == 0) ? 80 : 30);
        end
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised buffered serial transmitter for the board-level I/O bus; successor to the fixed 8N1 unbuffered transmit path.
- CPU-side writes go into a FIFO.
- An FSM serialises the bytes onto txd.
- Data width, parity, stop bits, baud divisor and FIFO depth are all configurable.
- Adds busy/empty/count status and a sticky overflow flag for polling firmware.

Parameters:
DIV, 434, clocks per bit (50 MHz / 115200); must be >= 2
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, 1 or 2
DEPTH, 16, FIFO entries, power of two >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
wr_en  in  1  push request
wr_data  in  DATA_BITS  data to push
ovf_clr  in  1  clears overflow flag
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  $clog2(DEPTH+1)  current FIFO occupancy
busy  out  1  frame in progress (FSM not IDLE)
overflow  out  1  sticky: a write was dropped
txd  out  1  serial line, idle high

Behaviour:
Reset values (reset low, asynchronous):
- txd=1, busy=0, full=0, empty=1, count=0, overflow=0.
- FIFO pointers cleared, FSM to IDLE, bit/baud counters 0.
- Reset mid-frame: the frame is abandoned, txd is high immediately, and no resumption occurs.

FIFO writes:
- A write is accepted on a rising edge when wr_en=1 and count<DEPTH.
- wr_en=1 with count==DEPTH drops the data and sets overflow.
- overflow holds until ovf_clr=1. If a drop and ovf_clr=1 occur on the same edge, set wins.
- Simultaneous push and pop: count is unchanged. The full check uses count before the edge, so a write at count==DEPTH is rejected even if a pop happens on the same edge.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: txd=1. On an edge with count>0: pop head into a shift register, go to START, set txd=0, load baud counter.
  - Latency: a write into an empty FIFO at edge N makes txd fall at edge N+1.
- Every bit (START, DATA, PARITY, STOP) lasts exactly DIV clocks. The baud counter counts DIV-1 down to 0; the state or bit advances on the edge where it reads 0.
- START -> DATA. Data is sent LSB first, DATA_BITS bits; a bit index counts 0..DATA_BITS-1.
- DATA -> PARITY if PARITY!=0, else -> STOP.
- PARITY bit: even = XOR of data bits; odd = its inverse. It is computed from the popped word, not from the FIFO.
- STOP: txd=1 for STOP_BITS*DIV clocks. At the end:
  - if count>0, pop immediately and enter START with no idle gap (back-to-back frames);
  - otherwise go to IDLE.
- busy=1 in every state except IDLE.

Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV clocks.

Signal registration and widths:
- txd is driven from a register, never combinationally.
- full, empty and count are registered and consistent with each other on every cycle.
- Counter widths: $clog2(DIV) for the baud counter, $clog2(DATA_BITS) for the bit index. No wrap is permitted beyond the terminal values.

Optional Feature:
UART_TX_DIV_PORT_EN
- Defined: adds input port div_in [15:0].
  - The divisor is latched from div_in at each START load, so a change never affects an in-flight frame.
  - div_in<2 is treated as 2.
- Undefined: port absent; the divisor is the constant DIV.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2;
  - DEFAULT_DIV=434.
- Sub-module sync_fifo #(WIDTH, DEPTH) provides:
  - inputs push/pop;
  - outputs full/empty/count/rdata;
  - async active-low reset.
- uart_tx_fifo contains the FSM, baud counter, shift register and overflow flag.

Test Plan:
- Idle after reset: reset low for 4 cycles then high, no writes for 100 cycles -> txd=1, busy=0, empty=1, count=0, overflow=0 throughout.
- Single 8N1 byte, DIV=4: write 0xA5 at edge N -> txd falls at N+1 and reads 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; busy drops after 40 cycles; empty=1.
- Parity and stop bits, DIV=4, PARITY=2, STOP_BITS=2: write 0x07 -> parity bit 1 and stop high for 8 cycles; with PARITY=1 -> parity bit 0.
- Back-to-back frames and overflow, DEPTH=4: write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles.
  - 0x11 is popped at the edge after its write, so 0x55 is accepted, count peaks at 4 and overflow stays 0.
  - A 6th write 0x66 while count=4 -> dropped, overflow=1.
  - Five frames go out with no idle cycles between the stop bit and the next start bit.
  - ovf_clr pulse -> overflow=0.
- Reset mid-frame: assert reset during bit 3 of 0x3C -> txd=1 and count=0 within the same cycle; after release, no residual frame is sent and the next write 0x81 is sent cleanly.
- With UART_TX_DIV_PORT_EN: div_in=8 for the first frame, changed to 3 mid-frame -> the first frame keeps 8-cycle bits and the next frame uses 3-cycle bits.
